// File: rtl/step_tracker_pkg.sv
// Shared encodings for the step tracker: status codes and FSM states.
package step_tracker_pkg;

  // One-hot sample classification; STABLE is the all-zero code.
  localparam logic [2:0] STATUS_INCR   = 3'b100;
  localparam logic [2:0] STATUS_DECR   = 3'b010;
  localparam logic [2:0] STATUS_ERROR  = 3'b001;
  localparam logic [2:0] STATUS_STABLE = 3'b000;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

endpackage

// File: rtl/step_classifier.sv
// Combinational classifier: compares a new sample against the tracked
// position using modulo-2^WIDTH distance and a maximum legal step.
module step_classifier
  import step_tracker_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_STEP = 1
) (
  input  logic [WIDTH-1:0] position,
  input  logic [WIDTH-1:0] in,
  output logic [2:0]       cls,
  output logic [WIDTH-1:0] step
);

  localparam logic [WIDTH-1:0] MaxStepW = WIDTH'(MAX_STEP);

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] neg_diff;

  assign diff     = in - position;
  assign neg_diff = position - in;

  // Forward and backward windows cannot overlap because MAX_STEP < 2^(WIDTH-1).
  always_comb begin
    cls  = STATUS_ERROR;
    step = '0;
    if (diff == '0) begin
      cls = STATUS_STABLE;
    end else if (diff <= MaxStepW) begin
      cls  = STATUS_INCR;
      step = diff;
    end else if (neg_diff <= MaxStepW) begin
      cls  = STATUS_DECR;
      step = neg_diff;
    end
  end

endmodule

// File: rtl/step_tracker.sv
// Wrap-around position tracker with step classification, saturating error
// count and automatic resync after a run of consecutive errors.
module step_tracker
  import step_tracker_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_STEP  = 1,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] in,
  input  logic             clear,
  output logic [2:0]       status,
  output logic             out_valid,
  output logic [WIDTH-1:0] position,
  output logic [WIDTH-1:0] step,
  output logic             locked,
  output logic             resync,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned CW = $clog2(ERR_LIMIT + 1);
  localparam logic [CW-1:0] ErrLimitW = CW'(ERR_LIMIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] position_q, position_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [2:0]       status_q, status_d;
  logic             out_valid_q, out_valid_d;
  logic             locked_q, locked_d;
  logic             resync_q, resync_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CW-1:0]    cons_q, cons_d;
  logic [CW-1:0]    cons_inc;

  logic [2:0]       cls;
  logic [WIDTH-1:0] cls_step;

  step_classifier #(
    .WIDTH    (WIDTH),
    .MAX_STEP (MAX_STEP)
  ) u_classifier (
    .position (position_q),
    .in       (in),
    .cls      (cls),
    .step     (cls_step)
  );

  assign cons_inc = cons_q + CW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any valid sample locks the tracker.
  always_comb begin
    state_d = state_q;
    if (valid) begin
      state_d = ST_LOCKED;
    end
  end

  // Output and datapath next values.
  always_comb begin
    position_d  = position_q;
    step_d      = step_q;
    status_d    = status_q;
    out_valid_d = valid;
    resync_d    = 1'b0;
    locked_d    = (state_d == ST_LOCKED);
    // clear wins over any increment decided below.
    err_d       = clear ? '0 : err_q;
    cons_d      = clear ? '0 : cons_q;
    if (valid) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          position_d = in;
          status_d   = STATUS_STABLE;
          step_d     = '0;
        end
        ST_LOCKED: begin
          status_d = cls;
          step_d   = cls_step;
          if (cls != STATUS_ERROR) begin
            position_d = in;
            cons_d     = '0;
          end else if (!clear) begin
            if (!(&err_q)) begin
              err_d = err_q + CNT_W'(1);
            end
            if (cons_inc == ErrLimitW) begin
              position_d = in;
              resync_d   = 1'b1;
              cons_d     = '0;
            end else begin
              cons_d = cons_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position_q  <= '0;
      step_q      <= '0;
      status_q    <= STATUS_STABLE;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      resync_q    <= 1'b0;
      err_q       <= '0;
      cons_q      <= '0;
    end else begin
      position_q  <= position_d;
      step_q      <= step_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      resync_q    <= resync_d;
      err_q       <= err_d;
      cons_q      <= cons_d;
    end
  end

  assign status    = status_q;
  assign out_valid = out_valid_q;
  assign position  = position_q;
  assign step      = step_q;
  assign locked    = locked_q;
  assign resync    = resync_q;
  assign err_count = err_q;

endmodule

// File: doc/step_tracker.md
# step_tracker

Parametrised position tracker for wrap-around sampled counters such as rotary or absolute encoders. Each valid sample is classified as STABLE, INCR, DECR or ERROR against the tracked position, with a configurable maximum legal step. The block keeps a saturating error count and re-synchronises its position after a run of consecutive errors. It sits between the sampled counter input and the downstream motion/accounting logic, and is the generalised successor of the fixed 4-bit single-step tracker.

## Interface
- WIDTH, 4: width of sampled position; position space is modulo 2^WIDTH.
- MAX_STEP, 1: largest legal step magnitude per sample; legal range 1 .. 2^(WIDTH-1)-1.
- ERR_LIMIT, 3: consecutive ERROR samples that trigger a resync; minimum 1.
- CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid  in  1  `in` carries a new sample this cycle.
- in  in  WIDTH  sampled position.
- clear  in  1  synchronous clear of `err_count` and the consecutive-error counter.
- status  out  3  one-hot classification: INCR=100, DECR=010, ERROR=001, STABLE=000.
- out_valid  out  1  `status`, `step`, `position` and `resync` are valid this cycle.
- position  out  WIDTH  tracked position.
- step  out  WIDTH  magnitude of the accepted step; 0 for STABLE and ERROR.
- locked  out  1  tracker holds a reference position.
- resync  out  1  one-cycle pulse: position was forced to `in` after ERR_LIMIT errors.
- err_count  out  CNT_W  total ERROR samples since reset or clear; saturates at all-ones.

## Operation
- The FSM has two states.
  - UNLOCKED: entered at reset.
  - LOCKED: entered on the first valid sample.
- UNLOCKED with valid:
  - position <= in; status STABLE; step 0; go to LOCKED.
  - The first sample is never an error.
- LOCKED with valid: d = (in - position) mod 2^WIDTH, computed in WIDTH bits.
  - d == 0: STABLE. Position held. Consecutive-error counter cleared.
  - 1 <= d <= MAX_STEP: INCR. position <= in; step = d. Consecutive-error counter cleared.
  - 2^WIDTH-MAX_STEP <= d <= 2^WIDTH-1: DECR. position <= in; step = 2^WIDTH-d. Consecutive-error counter cleared.
  - Any other d: ERROR. Position held. err_count increments unless already saturated. Consecutive-error counter increments.
- Resync: when an ERROR sample brings the consecutive-error count to ERR_LIMIT:
  - position <= in and resync = 1 for that output.
  - Consecutive-error counter returns to 0.
  - status still reports ERROR.
- Wrap-around comes from the modulo subtraction.
  - 15 -> 0 is INCR with step 1.
  - 0 -> 15 is DECR with step 1.
- With no valid input: all state is held, out_valid = 0, and resync = 0.
- clear:
  - Forces err_count and the consecutive-error counter to 0.
  - clear has priority over increments in the same cycle.
  - A simultaneous valid sample still updates status, position and step.
  - A simultaneous valid sample cannot trigger a resync in that cycle.
- Reset mid-operation returns the block immediately to UNLOCKED. The next sample re-locks the tracker.

## Timing
- All outputs are registered.
- A sample presented with valid at edge k appears on all outputs after edge k, with out_valid = 1, i.e. 1-cycle latency.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.
- Values on reset:
  - status 000, out_valid 0, position 0, step 0, locked 0, resync 0, err_count 0.
  - Internal: UNLOCKED, consecutive-error count 0.
- locked rises with the out_valid of the first sample.
- status, step and resync are meaningful only while out_valid is 1. They hold their last value otherwise, except resync, which is 0.

## Structure
- Package step_tracker_pkg:
  - Status encodings STATUS_INCR, STATUS_DECR, STATUS_ERROR, STATUS_STABLE.
  - FSM state enum: ST_UNLOCKED, ST_LOCKED.
- Sub-module step_classifier, purely combinational:
  - Inputs: WIDTH, MAX_STEP, position, in.
  - Outputs: class and step magnitude.
- The top level holds the FSM, the registers and the counters.

## Test plan
- Lock and basic steps (defaults): rst, then valid in=5 -> out_valid, STABLE, position 5, locked 1; then in=6 -> INCR, step 1, position 6; then in=5 -> DECR, step 1, position 5.
- Wrap-around: from position 15, in=0 -> INCR, position 0; then in=15 -> DECR, position 15.
- Error and resync: from position 3, in=9 three times:
  - Responses: ERROR, ERROR, ERROR with resync 1 on the third only.
  - Final state: position 9, err_count 3.
  - Then in=10 -> INCR.
- MAX_STEP=3, WIDTH=4: from position 14, in=1 -> INCR, step 3, position 1; then in=5 -> ERROR, position 1.
- Saturation and clear (CNT_W=2, ERR_LIMIT=8): five ERROR samples -> err_count stays 3; then clear together with an ERROR sample -> err_count 0, status ERROR, no resync.
- Reset mid-run: assert rst while LOCKED at position 7 -> all outputs return to their reset values immediately; next valid in=12 -> STABLE, position 12, locked 1.
